// File: rtl/dsky_relay_driver.sv
// DSKY relay-word transmitter: the monitor host writes the display image over
// a small register bus; changed fields are serialised as 15-bit OUT0 words
// ({RYWD[3:0], RYB[11:1]}), each held for a dwell window and then a zero gap.
// Dirty-bit index n (1..12) is the word's RYWD value (octal 01..14).
//
// Bus handshake: a transaction is a single-cycle strobe. write_en with addr and
// data_in commits on the rising edge where it is high. read_en returns the
// registered field on data_out for exactly the following cycle; data_out is 0
// at all other times. There is no back-pressure; the bus is always ready.
module dsky_relay_driver #(
  parameter logic [19:0] DWELL_CYCLES = 20'd550000,
  parameter logic [15:0] GAP_CYCLES   = 16'd1000,
  parameter logic [15:0] REG_BASE     = 16'h0040
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        read_en,
  input  logic        write_en,
  input  logic [15:0] addr,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  output logic [14:0] out0,
  output logic        busy,
  output logic        word_strobe
);

  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, GAP = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [19:0] cnt_q, cnt_d;
  logic [14:0] out0_q, out0_d;
  logic        strobe_q, strobe_d;
  logic        busy_q, busy_d;
  logic [15:0] data_out_q, data_out_d;
  logic [9:0]  prog_q, prog_d, verb_q, verb_d, noun_q, noun_d;
  logic [26:0] r1_q, r1_d, r2_q, r2_d, r3_q, r3_d;
  logic [7:0]  lamps_q, lamps_d;
  logic        enable_q, enable_d;
  logic [12:1] dirty_q, dirty_d;
  logic [3:0]  last_q, last_d;

  logic [15:0] off;
  logic        hit;
  logic [3:0]  reg_idx;
  logic [12:1] set_mask, clr_mask;
  logic [15:0] rd_val;
  logic        found;
  logic [3:0]  sel_idx;
  logic [4:0]  cand;
  logic [10:0] sel_ryb;

  // Address decode: registers live at REG_BASE+0..+11.
  always_comb begin
    off     = addr - REG_BASE;
    hit     = (addr >= REG_BASE) && (off < 16'd12);
    reg_idx = off[3:0];
  end

  // Register writes and the dirty bits each written field touches.
  always_comb begin
    prog_d   = prog_q;
    verb_d   = verb_q;
    noun_d   = noun_q;
    r1_d     = r1_q;
    r2_d     = r2_q;
    r3_d     = r3_q;
    lamps_d  = lamps_q;
    enable_d = enable_q;
    set_mask = '0;
    if (write_en && hit) begin
      case (reg_idx)
        4'd0:  begin prog_d  = data_in[9:0];  set_mask[11] = 1'b1; end
        4'd1:  begin verb_d  = data_in[9:0];  set_mask[10] = 1'b1; end
        4'd2:  begin noun_d  = data_in[9:0];  set_mask[9]  = 1'b1; end
        4'd3:  begin r1_d[14:0]  = data_in[14:0]; set_mask[7:6] = 2'b11; end
        4'd4:  begin r1_d[26:15] = data_in[11:0]; set_mask[8:6] = 3'b111; end
        4'd5:  begin r2_d[14:0]  = data_in[14:0]; set_mask[4:3] = 2'b11; end
        4'd6:  begin r2_d[26:15] = data_in[11:0]; set_mask[5:4] = 2'b11; end
        4'd7:  begin r3_d[14:0]  = data_in[14:0]; set_mask[2:1] = 2'b11; end
        4'd8:  begin r3_d[26:15] = data_in[11:0]; set_mask[3:1] = 3'b111; end
        4'd9:  begin lamps_d = data_in[7:0];  set_mask[12] = 1'b1; end
        4'd10: begin
          enable_d = data_in[0];
          if (data_in[1]) set_mask = '1;
        end
        default: ;
      endcase
    end
  end

  // Read mux; data_out is registered and zero unless a mapped read was strobed.
  always_comb begin
    rd_val = '0;
    case (reg_idx)
      4'd0:  rd_val = {6'b0, prog_q};
      4'd1:  rd_val = {6'b0, verb_q};
      4'd2:  rd_val = {6'b0, noun_q};
      4'd3:  rd_val = {1'b0, r1_q[14:0]};
      4'd4:  rd_val = {4'b0, r1_q[26:15]};
      4'd5:  rd_val = {1'b0, r2_q[14:0]};
      4'd6:  rd_val = {4'b0, r2_q[26:15]};
      4'd7:  rd_val = {1'b0, r3_q[14:0]};
      4'd8:  rd_val = {4'b0, r3_q[26:15]};
      4'd9:  rd_val = {8'b0, lamps_q};
      4'd10: rd_val = {15'b0, enable_q};
      4'd11: rd_val = {3'b0, busy_q, dirty_q};
      default: rd_val = '0;
    endcase
    data_out_d = (read_en && hit) ? rd_val : 16'h0000;
  end

  // Round-robin pick of the first dirty word after the last one sent (12 wraps to 1).
  always_comb begin
    found   = 1'b0;
    sel_idx = 4'd0;
    for (int k = 1; k <= 12; k++) begin
      cand = {1'b0, last_q} + k[4:0];
      if (cand > 5'd12) cand = cand - 5'd12;
      if (!found && dirty_q[cand[3:0]]) begin
        found   = 1'b1;
        sel_idx = cand[3:0];
      end
    end
  end

  // RYB[11:1] encoding of the selected word.
  always_comb begin
    sel_ryb = '0;
    case (sel_idx)
      4'd1:  sel_ryb = {r3_q[25], r3_q[9:0]};
      4'd2:  sel_ryb = {r3_q[26], r3_q[19:10]};
      4'd3:  sel_ryb = {1'b0, r2_q[4:0], r3_q[24:20]};
      4'd4:  sel_ryb = {r2_q[25], r2_q[14:5]};
      4'd5:  sel_ryb = {r2_q[26], r2_q[24:15]};
      4'd6:  sel_ryb = {r1_q[25], r1_q[9:0]};
      4'd7:  sel_ryb = {r1_q[26], r1_q[19:10]};
      4'd8:  sel_ryb = {6'b0, r1_q[24:20]};
      4'd9:  sel_ryb = {1'b0, noun_q};
      4'd10: sel_ryb = {1'b0, verb_q};
      4'd11: sel_ryb = {1'b0, prog_q};
      4'd12: sel_ryb = {2'b0, lamps_q[7:6], 1'b0, lamps_q[5:0]};
      default: sel_ryb = '0;
    endcase
  end

  // IDLE/SEND/GAP sequencing; a set in the same cycle as a clear wins.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    out0_d   = out0_q;
    strobe_d = 1'b0;
    last_d   = last_q;
    clr_mask = '0;
    case (state_q)
      IDLE: begin
        if (enable_q && found) begin
          out0_d            = {sel_idx, sel_ryb};
          clr_mask[sel_idx] = 1'b1;
          strobe_d          = 1'b1;
          last_d            = sel_idx;
          cnt_d             = DWELL_CYCLES - 20'd1;
          state_d           = SEND;
        end
      end
      SEND: begin
        if (cnt_q == 20'd0) begin
          out0_d  = '0;
          cnt_d   = {4'b0, GAP_CYCLES} - 20'd1;
          state_d = GAP;
        end else begin
          cnt_d = cnt_q - 20'd1;
        end
      end
      GAP: begin
        if (cnt_q == 20'd0) state_d = IDLE;
        else                cnt_d   = cnt_q - 20'd1;
      end
      default: state_d = IDLE;
    endcase
    dirty_d = (dirty_q & ~clr_mask) | set_mask;
    busy_d  = (state_d != IDLE);
  end

  // State and register file update with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      out0_q     <= '0;
      strobe_q   <= 1'b0;
      busy_q     <= 1'b0;
      data_out_q <= '0;
      prog_q     <= '0;
      verb_q     <= '0;
      noun_q     <= '0;
      r1_q       <= '0;
      r2_q       <= '0;
      r3_q       <= '0;
      lamps_q    <= '0;
      enable_q   <= 1'b0;
      dirty_q    <= '0;
      last_q     <= 4'd12;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      out0_q     <= out0_d;
      strobe_q   <= strobe_d;
      busy_q     <= busy_d;
      data_out_q <= data_out_d;
      prog_q     <= prog_d;
      verb_q     <= verb_d;
      noun_q     <= noun_d;
      r1_q       <= r1_d;
      r2_q       <= r2_d;
      r3_q       <= r3_d;
      lamps_q    <= lamps_d;
      enable_q   <= enable_d;
      dirty_q    <= dirty_d;
      last_q     <= last_d;
    end
  end

  assign out0        = out0_q;
  assign word_strobe = strobe_q;
  assign busy        = busy_q;
  assign data_out    = data_out_q;

endmodule

// File: tb/tb_dsky_relay_driver.sv
// Bench for dsky_relay_driver with a short dwell/gap. Stimulus tasks push the
// expected relay words and read data into queues; a monitor pops and compares
// whenever the DUT strobes a word or returns read data.
module tb_dsky_relay_driver;

  localparam int DWELL = 20;
  localparam int GAP   = 4;

  localparam logic [15:0] A_PROG   = 16'h0040;
  localparam logic [15:0] A_VERB   = 16'h0041;
  localparam logic [15:0] A_NOUN   = 16'h0042;
  localparam logic [15:0] A_R1L    = 16'h0043;
  localparam logic [15:0] A_R1H    = 16'h0044;
  localparam logic [15:0] A_R3L    = 16'h0047;
  localparam logic [15:0] A_LAMPS  = 16'h0049;
  localparam logic [15:0] A_CTRL   = 16'h004A;
  localparam logic [15:0] A_STATUS = 16'h004B;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        read_en = 1'b0;
  logic        write_en = 1'b0;
  logic [15:0] addr = '0;
  logic [15:0] data_in = '0;
  logic [15:0] data_out;
  logic [14:0] out0;
  logic        busy;
  logic        word_strobe;

  logic [14:0] exp_word_q[$];
  logic [15:0] exp_rd_q[$];
  int          checks = 0;
  int          errors = 0;
  logic        rd_seen = 1'b0;

  dsky_relay_driver #(
    .DWELL_CYCLES(20'd20),
    .GAP_CYCLES  (16'd4),
    .REG_BASE    (16'h0040)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .read_en    (read_en),
    .write_en   (write_en),
    .addr       (addr),
    .data_in    (data_in),
    .data_out   (data_out),
    .out0       (out0),
    .busy       (busy),
    .word_strobe(word_strobe)
  );

  // Clock and read-return tracking
  always #5 clk = ~clk;
  always @(posedge clk) rd_seen <= read_en && !rst;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Driver tasks
  task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
    @(posedge clk); #1;
    write_en = 1'b1; addr = a; data_in = d;
    @(posedge clk); #1;
    write_en = 1'b0; addr = '0; data_in = '0;
  endtask

  task automatic bus_read(input logic [15:0] a, input logic [15:0] exp);
    @(posedge clk); #1;
    read_en = 1'b1; addr = a;
    exp_rd_q.push_back(exp);
    @(posedge clk); #1;
    read_en = 1'b0; addr = '0;
  endtask

  task automatic wait_busy();
    int n;
    n = 0;
    while (busy !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    if (busy !== 1'b1) chk("wait_busy_timeout", {31'b0, busy}, 32'd1);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    repeat (3) @(negedge clk);
    while (!(busy === 1'b0 && exp_word_q.size() == 0) && n < 2000) begin
      @(negedge clk); n++;
    end
    if (n >= 2000) chk("wait_done_timeout", exp_word_q.size(), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  // Scoreboard monitor: word content, dwell/gap timing, read data
  int          since = 0;
  logic        active = 1'b0;
  logic [14:0] cur_word = '0;
  always @(negedge clk) begin
    if (rst) begin
      active = 1'b0;
    end else begin
      if (word_strobe) begin
        if (active) chk("period_short", since, DWELL + GAP);
        if (exp_word_q.size() == 0) begin
          chk("word_unexpected", {17'b0, out0}, 32'd0);
          if (out0 == 15'd0) begin
            errors++;
            $display("FAIL word_unexpected: strobe with empty queue at %0t", $time);
          end
        end else begin
          chk("word_value", {17'b0, out0}, {17'b0, exp_word_q.pop_front()});
        end
        active   = 1'b1;
        since    = 0;
        cur_word = out0;
      end else if (active) begin
        since++;
        if (since < DWELL)            chk("dwell_hold", {17'b0, out0}, {17'b0, cur_word});
        else if (since < DWELL + GAP) chk("gap_zero", {17'b0, out0}, 32'd0);
        else begin
          chk("idle_after_gap", {31'b0, busy}, 32'd0);
          active = 1'b0;
        end
      end else begin
        chk("idle_out0", {17'b0, out0}, 32'd0);
      end
      if (rd_seen) begin
        if (exp_rd_q.size() == 0) chk("read_unexpected", {16'b0, data_out}, 32'hFFFF_FFFF);
        else chk("read_data", {16'b0, data_out}, {16'b0, exp_rd_q.pop_front()});
      end else begin
        chk("data_out_idle", {16'b0, data_out}, 32'd0);
      end
    end
  end

  initial begin
    // 1: reset state, enable with nothing dirty
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out0", {17'b0, out0}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_strobe", {31'b0, word_strobe}, 32'd0);
    chk("rst_data_out", {16'b0, data_out}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    bus_write(A_CTRL, 16'h0001);
    repeat (200) @(negedge clk);
    chk("t1_busy", {31'b0, busy}, 32'd0);
    bus_read(A_CTRL, 16'h0001);
    bus_read(A_STATUS, 16'h0000);

    // 2: PROG=0x155 (upper data bits ignored) -> word 13 = {4'hB, 0, 0x155}
    bus_write(A_CTRL, 16'h0000);
    bus_write(A_PROG, 16'hFD55);
    bus_read(A_PROG, 16'h0155);
    exp_word_q.push_back(15'h5955);
    bus_write(A_CTRL, 16'h0001);
    wait_done();
    bus_read(A_STATUS, 16'h0000);

    // 3: R1H=0xAA0 -> r1[26]=1, r1[25]=0, r1[24:20]=5'b10101, low bits 0
    bus_write(A_CTRL, 16'h0000);
    bus_write(A_R1H, 16'hFAA0);
    bus_read(A_R1H, 16'h0AA0);
    bus_read(A_R1L, 16'h0000);
    exp_word_q.push_back(15'h3000);  // 06: {6, 0, 0}
    exp_word_q.push_back(15'h3C00);  // 07: {7, 1, 0}
    exp_word_q.push_back(15'h4015);  // 10: {8, 0, 0x015}
    bus_write(A_CTRL, 16'h0001);
    wait_done();

    // 4: after word 13, dirty 14, 01, 02 -> 14 goes first (wrap)
    bus_write(A_CTRL, 16'h0000);
    bus_write(A_PROG, 16'h00AA);
    exp_word_q.push_back(15'h58AA);
    bus_write(A_CTRL, 16'h0001);
    wait_done();
    bus_write(A_CTRL, 16'h0000);
    bus_write(A_LAMPS, 16'h01FF);
    bus_write(A_R3L, 16'h7FFF);
    bus_read(A_STATUS, 16'h0803);
    bus_read(A_LAMPS, 16'h00FF);
    exp_word_q.push_back(15'h61BF);  // 14: {12, 0, 0x1BF}
    exp_word_q.push_back(15'h0BFF);  // 01: {1, 0, 0x3FF}
    exp_word_q.push_back(15'h101F);  // 02: {2, 0, 0x01F}
    bus_write(A_CTRL, 16'h0001);
    wait_done();

    // 5: VERB rewritten mid-SEND -> full dwell of old value, then re-send
    exp_word_q.push_back(15'h5001);
    bus_write(A_VERB, 16'h0001);
    wait_busy();
    repeat (5) @(negedge clk);
    exp_word_q.push_back(15'h5002);
    bus_write(A_VERB, 16'h0002);
    wait_done();

    // enable cleared mid-word: word completes, dirty bits retained
    exp_word_q.push_back(15'h4803);
    bus_write(A_NOUN, 16'h0003);
    wait_busy();
    repeat (3) @(negedge clk);
    bus_write(A_CTRL, 16'h0000);
    bus_write(A_PROG, 16'h0001);
    wait_done();
    repeat (60) @(negedge clk);
    chk("disabled_busy", {31'b0, busy}, 32'd0);
    bus_read(A_STATUS, 16'h0400);
    bus_read(A_CTRL, 16'h0000);
    exp_word_q.push_back(15'h5801);
    bus_write(A_CTRL, 16'h0001);
    wait_done();

    // 6: reset mid-SEND
    exp_word_q.push_back(15'h5003);
    bus_write(A_VERB, 16'h0003);
    wait_busy();
    repeat (4) @(negedge clk);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_mid_out0", {17'b0, out0}, 32'd0);
    chk("rst_mid_busy", {31'b0, busy}, 32'd0);
    chk("rst_mid_strobe", {31'b0, word_strobe}, 32'd0);
    rst = 1'b0;
    bus_read(A_STATUS, 16'h0000);
    bus_read(A_PROG, 16'h0000);
    bus_read(A_CTRL, 16'h0000);
    bus_write(16'h003F, 16'hFFFF);
    bus_read(16'h004C, 16'h0000);
    bus_read(16'h003F, 16'h0000);
    repeat (50) @(negedge clk);
    chk("post_rst_busy", {31'b0, busy}, 32'd0);

    // Final report
    chk("word_q_empty", exp_word_q.size(), 32'd0);
    chk("rd_q_empty", exp_rd_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
